fifo_ms_nsink: RTL

Multi-sink broadcast FIFO for the dataflow fabric: one producer writes tokens, and each of `SINKS` consumer actors reads every token through its own independent read pointer and handshake. It generalises the two-flux FIFO to any sink count. Each sink gets a private first-word-fall-through data bus, so actors with different consumption rates can share one producer. Storage is freed only when the slowest enabled sink has consumed a word.

---
 rtl/fifo_ms_nsink.sv | 96 +++++++++
 1 files changed

// File: rtl/fifo_ms_nsink.sv
// Broadcast FIFO: one producer, SINKS independent first-word-fall-through readers.
// Optional per-sink enable mask via FIFO_MS_SINK_MASK_EN.
module fifo_ms_nsink #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned SINKS = 2
) (
   input  logic                   ck,
   input  logic                   rst,
   input  logic                   wr,
   input  logic [WIDTH-1:0]       datain,
   output logic                   full,
   input  logic [SINKS-1:0]       rd,
   output logic [SINKS-1:0]       empty,
   output logic [SINKS*WIDTH-1:0] dataout
`ifdef FIFO_MS_SINK_MASK_EN
   ,
   input  logic [SINKS-1:0]       sink_en
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    r_wp;
   logic [PW-1:0]    r_rp  [SINKS];
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [SINKS-1:0] w_en;
   logic [PW-1:0]    w_occ    [SINKS];
   logic [PW-1:0]    w_rp_nxt [SINKS];
   logic [SINKS-1:0] w_empty;
   logic [SINKS-1:0] w_full_vec;
   logic             w_full;
   logic             w_wr_ok;
   logic [PW-1:0]    w_wp_nxt;

`ifdef FIFO_MS_SINK_MASK_EN
   assign w_en = sink_en;
`else
   assign w_en = '1;
`endif

   // Wrap bit makes occ == DEPTH distinguishable from occ == 0.
   always_comb begin
      for (int i = 0; i < SINKS; i++) begin
         w_occ[i]      = r_wp - r_rp[i];
         w_empty[i]    = (w_occ[i] == '0) || !w_en[i];
         w_full_vec[i] = (w_occ[i] == PW'(DEPTH)) && w_en[i];
      end
   end

   assign w_full   = |w_full_vec;
   assign w_wr_ok  = wr && !w_full;
   assign w_wp_nxt = w_wr_ok ? r_wp + PW'(1) : r_wp;

   // A disabled sink shadows the post-edge write pointer.
   always_comb begin
      for (int i = 0; i < SINKS; i++) begin
         w_rp_nxt[i] = r_rp[i];
         if (!w_en[i]) begin
            w_rp_nxt[i] = w_wp_nxt;
         end else if (rd[i] && !w_empty[i]) begin
            w_rp_nxt[i] = r_rp[i] + PW'(1);
         end
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         r_wp <= '0;
         for (int i = 0; i < SINKS; i++) begin
            r_rp[i] <= '0;
         end
         for (int j = 0; j < DEPTH; j++) begin
            r_mem[j] <= '0;
         end
      end else begin
         if (w_wr_ok) begin
            r_mem[r_wp[AW-1:0]] <= datain;
         end
         r_wp <= w_wp_nxt;
         for (int i = 0; i < SINKS; i++) begin
            r_rp[i] <= w_rp_nxt[i];
         end
      end
   end

   for (genvar g = 0; g < SINKS; g++) begin : g_out
      assign dataout[g*WIDTH +: WIDTH] = r_mem[r_rp[g][AW-1:0]];
   end

   assign full  = w_full;
   assign empty = w_empty;

endmodule
